// File: rtl/ila_capture_ctrl_pkg.sv
// ila_capture_ctrl_pkg
//  Shared definitions for the ILA capture sequencer and its read walker.
//  - state_e: sequencer states, IDLE through DONE.
//  - calc_nwords/calc_sel_w: how many DATA_W words make up one sample and
//    how wide the word selector must be. ila_core derives the same values.
package ila_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARM     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_READ    = 3'd4,
    ST_STREAM  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  function automatic int calc_nwords(input int signal_w, input int data_w);
    return (signal_w + data_w - 1) / data_w;
  endfunction

  // A single-word sample still needs a 1-bit selector port.
  function automatic int calc_sel_w(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/ila_rd_walker.sv
// ila_rd_walker
//  Walks the capture buffer during readout: value_select steps through the
//  words of one sample, then wraps to 0 and index advances to the next sample.
//  Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   clear_i          restart the walk at index 0, word 0
//   advance_i        step to the next word (only for words that are not last)
//   n_captured_i     number of samples in the dump
//   index_o          buffer read address
//   value_select_o   word within the current sample
//   last_o           current position is the final word of the dump
module ila_rd_walker #(
  parameter int BUFFER_W = 10,
  parameter int NWORDS   = 1,
  parameter int SEL_W    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                advance_i,
  input  logic [BUFFER_W-1:0] n_captured_i,
  output logic [BUFFER_W-1:0] index_o,
  output logic [SEL_W-1:0]    value_select_o,
  output logic                last_o
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NWORDS - 1);

  logic [BUFFER_W-1:0] index_q, index_d;
  logic [SEL_W-1:0]    sel_q, sel_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      index_q <= '0;
      sel_q   <= '0;
    end else begin
      index_q <= index_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    index_d = index_q;
    sel_d   = sel_q;
    if (clear_i) begin
      index_d = '0;
      sel_d   = '0;
    end else if (advance_i) begin
      if (sel_q == SEL_MAX) begin
        sel_d   = '0;
        index_d = index_q + BUFFER_W'(1);
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  assign index_o        = index_q;
  assign value_select_o = sel_q;
  assign last_o         = (index_q == n_captured_i - BUFFER_W'(1)) && (sel_q == SEL_MAX);

endmodule

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl
//  Sequencer for one ila_core: clears the core, arms it, waits for the target
//  sample count / buffer full / timeout / abort, then streams every captured
//  word out over a valid/ready port (index ascending, word ascending).
//  Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, abort_i      capture control pulses
//   cfg_misc_i            misc_enabled[31:1] applied while armed
//   cfg_target_i          samples to capture, 0 = until full
//   cfg_timeout_i         capture cycle limit, 0 = none
//   samples_i, value_i    ila_core status and read data
//   misc_enabled_o        to ila_core, bit0 = soft reset
//   index_o, value_select_o  ila_core read address / word select
//   out_data_o, out_valid_o, out_ready_i, out_last_o  readout stream
//   busy_o, done_o, timed_out_o, n_captured_o         status
module ila_capture_ctrl
  import ila_capture_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SIGNAL_W = 32,
  parameter int BUFFER_W = 10,
  parameter int READ_LAT = 2,
  parameter int CLR_CYC  = 4,
  parameter int SYNC_CYC = 3,
  localparam int NWORDS  = calc_nwords(SIGNAL_W, DATA_W),
  localparam int SEL_W   = calc_sel_w(NWORDS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [31:0]         cfg_misc_i,
  input  logic [BUFFER_W-1:0] cfg_target_i,
  input  logic [31:0]         cfg_timeout_i,
  input  logic [BUFFER_W-1:0] samples_i,
  input  logic [DATA_W-1:0]   value_i,
  output logic [31:0]         misc_enabled_o,
  output logic [BUFFER_W-1:0] index_o,
  output logic [SEL_W-1:0]    value_select_o,
  output logic [DATA_W-1:0]   out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timed_out_o,
  output logic [BUFFER_W-1:0] n_captured_o
);

  localparam int CNT_W = 8;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         tcnt_q, tcnt_d;
  logic [31:0]         misc_q, misc_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                timed_out_q, timed_out_d;
  logic [BUFFER_W-1:0] ncap_q, ncap_d;
  logic [BUFFER_W-1:0] tgt_q, tgt_d;
  logic [31:0]         timeout_q, timeout_d;

  logic walk_clear, walk_adv, walk_last;

  // Capture end conditions, evaluated only in CAPTURE.
  logic                hit_tgt, hit_full, hit_to, cap_exit, to_only;
  logic [BUFFER_W-1:0] cap_count;

  assign hit_tgt   = (tgt_q != '0) && (samples_i >= tgt_q);
  assign hit_full  = (samples_i == {BUFFER_W{1'b1}});
  assign hit_to    = (timeout_q != '0) && (tcnt_q == timeout_q - 32'd1);
  assign cap_exit  = hit_tgt || hit_full || hit_to || abort_i;
  // timed_out means the timer alone ended the capture; a coincident count wins.
  assign to_only   = hit_to && !hit_tgt && !hit_full && !abort_i;
  assign cap_count = ((tgt_q != '0) && (samples_i > tgt_q)) ? tgt_q : samples_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      misc_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      timed_out_q <= 1'b0;
      ncap_q      <= '0;
      tgt_q       <= '0;
      timeout_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      misc_q      <= misc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      timed_out_q <= timed_out_d;
      ncap_q      <= ncap_d;
      tgt_q       <= tgt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    misc_d      = misc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    timed_out_d = timed_out_q;
    ncap_d      = ncap_q;
    tgt_d       = tgt_q;
    timeout_d   = timeout_q;
    walk_clear  = 1'b0;
    walk_adv    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          // Bit0 is the core's soft reset; it is forced high for the clear phase.
          misc_d      = cfg_misc_i | 32'd1;
          timed_out_d = 1'b0;
          tgt_d       = cfg_target_i;
          timeout_d   = cfg_timeout_i;
        end
      end

      ST_CLEAR: begin
        if (cnt_q == CNT_W'(CLR_CYC - 1)) begin
          state_d   = ST_ARM;
          cnt_d     = '0;
          misc_d[0] = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Lets the cleared sample count cross the synchronizer before it is trusted.
      ST_ARM: begin
        if (cnt_q == CNT_W'(SYNC_CYC - 1)) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CAPTURE: begin
        if (cap_exit) begin
          ncap_d      = cap_count;
          timed_out_d = to_only;
          walk_clear  = 1'b1;
          if (cap_count == '0) begin
            state_d = ST_DONE;
            misc_d  = '0;
          end else begin
            state_d = ST_READ;
            cnt_d   = '0;
          end
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end

      ST_READ: begin
        if (abort_i) begin
          state_d     = ST_DONE;
          misc_d      = '0;
          out_valid_d = 1'b0;
        end else if (cnt_q == CNT_W'(READ_LAT - 1)) begin
          state_d     = ST_STREAM;
          cnt_d       = '0;
          out_data_d  = value_i;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STREAM: begin
        if (abort_i) begin
          state_d     = ST_DONE;
          misc_d      = '0;
          out_valid_d = 1'b0;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (walk_last) begin
            state_d = ST_DONE;
            misc_d  = '0;
          end else begin
            walk_adv = 1'b1;
            state_d  = ST_READ;
            cnt_d    = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  ila_rd_walker #(
    .BUFFER_W (BUFFER_W),
    .NWORDS   (NWORDS),
    .SEL_W    (SEL_W)
  ) u_walker (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (walk_clear),
    .advance_i      (walk_adv),
    .n_captured_i   (ncap_q),
    .index_o        (index_o),
    .value_select_o (value_select_o),
    .last_o         (walk_last)
  );

  assign misc_enabled_o = misc_q;
  assign out_data_o     = out_data_q;
  assign out_valid_o    = out_valid_q;
  assign out_last_o     = out_valid_q && walk_last;
  assign busy_o         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o         = (state_q == ST_DONE);
  assign timed_out_o    = timed_out_q;
  assign n_captured_o   = ncap_q;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// tb_ila_capture_ctrl
//  Two sequencers share the control inputs: dut0 has one word per sample,
//  dut1 two words per sample. Each has a small ila_core read model (one
//  register stage after index/value_select, so data is ready READ_LAT cycles
//  after the address moves). Expected words are queued per port when a
//  capture starts and popped as the port hands words over.
module tb_ila_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1, abort, ready;
  logic [31:0] cfgMisc, cfgTimeout;
  logic [3:0]  cfgTarget, samples;

  logic [31:0] misc0, misc1, od0, od1, val0, val1;
  logic [3:0]  idx0, idx1, nc0, nc1;
  logic        sel0, sel1;
  logic        ov0, ov1, ol0, ol1, busy0, busy1, done0, done1, to0, to1;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] expq [2][$];
  int          words [2];
  logic        prevStall [2];
  logic [31:0] prevData [2];
  logic        prevLast [2];
  logic [3:0]  rampCap;

  always #5 clk = ~clk;

  ila_capture_ctrl #(.DATA_W(32), .SIGNAL_W(32), .BUFFER_W(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .abort_i(abort),
    .cfg_misc_i(cfgMisc), .cfg_target_i(cfgTarget), .cfg_timeout_i(cfgTimeout),
    .samples_i(samples), .value_i(val0), .misc_enabled_o(misc0),
    .index_o(idx0), .value_select_o(sel0), .out_data_o(od0),
    .out_valid_o(ov0), .out_ready_i(ready), .out_last_o(ol0),
    .busy_o(busy0), .done_o(done0), .timed_out_o(to0), .n_captured_o(nc0)
  );

  ila_capture_ctrl #(.DATA_W(32), .SIGNAL_W(64), .BUFFER_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .abort_i(abort),
    .cfg_misc_i(cfgMisc), .cfg_target_i(cfgTarget), .cfg_timeout_i(cfgTimeout),
    .samples_i(samples), .value_i(val1), .misc_enabled_o(misc1),
    .index_o(idx1), .value_select_o(sel1), .out_data_o(od1),
    .out_valid_o(ov1), .out_ready_i(ready), .out_last_o(ol1),
    .busy_o(busy1), .done_o(done1), .timed_out_o(to1), .n_captured_o(nc1)
  );

  function automatic logic [31:0] mkWord(input logic [3:0] idx, input logic sel);
    return 32'hC0DE_0000 | {20'd0, idx, 7'd0, sel} | (32'(idx) << 12);
  endfunction

  always @(posedge clk) begin
    val0 <= mkWord(idx0, sel0);
    val1 <= mkWord(idx1, sel1);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitorPort(input int p, input logic v, input logic [31:0] d, input logic l);
    logic [32:0] e;
    if (v && prevStall[p]) begin
      checkOutput("stall_data", 64'(d), 64'(prevData[p]));
      checkOutput("stall_last", 64'(l), 64'(prevLast[p]));
    end
    if (v && ready) begin
      words[p]++;
      if (expq[p].size() == 0) begin
        checkOutput("unexpected_word", 64'(d), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = expq[p].pop_front();
        checkOutput("word_data", 64'(d), 64'(e[31:0]));
        checkOutput("word_last", 64'(l), 64'(e[32]));
      end
    end
    prevStall[p] = v && !ready;
    prevData[p]  = d;
    prevLast[p]  = l;
  endtask

  // Outputs are looked at on the falling edge; inputs move 1ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitorPort(0, ov0, od0, ol0);
    monitorPort(1, ov1, od1, ol1);
    @(posedge clk);
    #1;
    if (samples < rampCap) samples = samples + 4'd1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_misc"}, 64'(misc0), 64'd0);
    checkOutput({tag, "_index"}, 64'(idx0), 64'd0);
    checkOutput({tag, "_sel"}, 64'(sel0), 64'd0);
    checkOutput({tag, "_data"}, 64'(od0), 64'd0);
    checkOutput({tag, "_valid"}, 64'(ov0), 64'd0);
    checkOutput({tag, "_last"}, 64'(ol0), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy0), 64'd0);
    checkOutput({tag, "_done"}, 64'(done0), 64'd0);
    checkOutput({tag, "_timed_out"}, 64'(to0), 64'd0);
    checkOutput({tag, "_ncap"}, 64'(nc0), 64'd0);
  endtask

  task automatic pulseStart(input int p);
    if (p == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // One full capture on port p; expLat < 0 skips the latency check.
  task automatic applyStimulus(input int p, input logic [3:0] tgt, input logic [31:0] tmo,
                               input logic [3:0] cap, input logic [31:0] misc, input int expN,
                               input logic expTo, input int expLat, input int stallAt);
    int   nw, cnt;
    logic stalled;
    nw = (p == 0) ? 1 : 2;
    for (int i = 0; i < expN; i++)
      for (int s = 0; s < nw; s++)
        expq[p].push_back({(i == expN - 1) && (s == nw - 1), mkWord(4'(i), s[0])});
    words[p]   = 0;
    samples    = 4'd0;
    rampCap    = cap;
    cfgTarget  = tgt;
    cfgTimeout = tmo;
    cfgMisc    = misc;
    ready      = 1'b1;
    stalled    = 1'b0;
    pulseStart(p);
    checkOutput("busy_after_start", 64'((p == 0) ? busy0 : busy1), 64'd1);
    checkOutput("done_drops", 64'((p == 0) ? done0 : done1), 64'd0);
    checkOutput("misc_clear", 64'((p == 0) ? misc0 : misc1), 64'(misc | 32'd1));
    cnt = 0;
    while (!((p == 0) ? (ov0 | done0) : (ov1 | done1)) && cnt < 400) begin
      tick();
      cnt++;
    end
    if (expLat >= 0) checkOutput("latency", 64'(cnt), 64'(expLat));
    if (expN > 0)
      checkOutput("misc_armed", 64'((p == 0) ? misc0 : misc1), 64'(misc & ~32'd1));
    cnt = 0;
    while (!((p == 0) ? done0 : done1) && cnt < 2000) begin
      if (stallAt >= 0 && !stalled && words[p] == stallAt) begin
        ready   = 1'b0;
        stalled = 1'b1;
        if (p == 0) start0 = 1'b1; else start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (9) tick();
        ready = 1'b1;
      end else begin
        tick();
      end
      cnt++;
    end
    checkOutput("done_reached", 64'((p == 0) ? done0 : done1), 64'd1);
    checkOutput("word_count", 64'(words[p]), 64'(expN * nw));
    checkOutput("queue_empty", 64'(expq[p].size()), 64'd0);
    checkOutput("n_captured", 64'((p == 0) ? nc0 : nc1), 64'(expN));
    checkOutput("timed_out", 64'((p == 0) ? to0 : to1), 64'(expTo));
    checkOutput("misc_done", 64'((p == 0) ? misc0 : misc1), 64'd0);
    expq[p].delete();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; ready = 1'b1;
    cfgMisc = 32'd0; cfgTarget = 4'd0; cfgTimeout = 32'd0; samples = 4'd0; rampCap = 4'd0;
    for (int p = 0; p < 2; p++) begin
      words[p] = 0; prevStall[p] = 1'b0; prevData[p] = '0; prevLast[p] = 1'b0;
    end
    #23;
    checkResetValues("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    $display("[TB] target 5, one word per sample");
    applyStimulus(0, 4'd5, 32'd0, 4'd7, 32'h8000_0F0F, 5, 1'b0, 10, -1);
    $display("[TB] target 3, two words per sample");
    applyStimulus(1, 4'd3, 32'd0, 4'd7, 32'h1234_5679, 3, 1'b0, 10, -1);
    $display("[TB] target 0, buffer full");
    applyStimulus(0, 4'd0, 32'd0, 4'd15, 32'hFFFF_FFFE, 15, 1'b0, -1, -1);
    $display("[TB] timeout 100, samples stuck at 2");
    applyStimulus(0, 4'd0, 32'd100, 4'd2, 32'h0000_00A0, 2, 1'b1, 109, -1);
    $display("[TB] timeout with nothing captured");
    applyStimulus(0, 4'd0, 32'd5, 4'd0, 32'h0000_0002, 0, 1'b1, 12, -1);
    $display("[TB] consumer stall mid-dump");
    applyStimulus(0, 4'd5, 32'd0, 4'd7, 32'h5555_AAAA, 5, 1'b0, 10, 2);
    $display("[TB] two-word timeout exactly at target");
    applyStimulus(1, 4'd2, 32'd9, 4'd2, 32'h0000_0010, 2, 1'b0, -1, -1);

    $display("[TB] abort while streaming");
    ready = 1'b0; samples = 4'd0; rampCap = 4'd7;
    cfgTarget = 4'd5; cfgTimeout = 32'd0; cfgMisc = 32'h0000_0100;
    pulseStart(0);
    cnt = 0;
    while (!ov0 && cnt < 100) begin tick(); cnt++; end
    checkOutput("abort_pre_valid", 64'(ov0), 64'd1);
    checkOutput("abort_pre_last", 64'(ol0), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_valid", 64'(ov0), 64'd0);
    checkOutput("abort_last", 64'(ol0), 64'd0);
    checkOutput("abort_done", 64'(done0), 64'd1);
    checkOutput("abort_misc", 64'(misc0), 64'd0);
    ready = 1'b1;
    prevStall[0] = 1'b0;

    $display("[TB] reset during capture");
    samples = 4'd0; rampCap = 4'd2; cfgTarget = 4'd0; cfgTimeout = 32'd0;
    cfgMisc = 32'hDEAD_BEEF;
    pulseStart(0);
    repeat (12) tick();
    checkOutput("capture_busy", 64'(busy0), 64'd1);
    checkOutput("capture_misc", 64'(misc0), 64'hDEAD_BEEE);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    checkOutput("idle_after_reset", 64'(busy0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
